fp_round_pack: RTL and testbench

Post-normalization rounding and packing stage of the FPU adder datapath. Consumes the 27-bit normalized mantissa and the 2-bit exponent-update code from the left/right normalization shifter, together with the operand sign and pre-shift exponent. Applies the exponent update, rounds to 24 significant bits, renormalizes on rounding carry, handles overflow and underflow, and emits a packed IEEE-754 single-precision result. It is a 2-stage pipeline with valid/ready handshaking on both sides.

---
 rtl/fp_round_pack.sv | 90 +++++++++
 tb/tb_fp_round_pack.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// fp_round_pack: FPU adder round/renormalize/pack stage; define FPU_RNE_EN for round-to-nearest-even, otherwise truncation
module fp_round_pack #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [1:0]        in_exp_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);
    localparam logic [EXP_W+1:0] one     = 1;
    localparam logic [EXP_W+1:0] neg_one = '1;
    localparam logic [EXP_W+1:0] zero_e  = '0;
    logic                adv, round_up, inexact0, zero;
    logic [EXP_W+1:0]    exp_adj, exp_f;
    logic                s1_valid, s1_sign, s1_rup, s1_inx, s1_zero;
    logic [EXP_W+1:0]    s1_exp;
    logic [MANT_W-4:0]   s1_mant;
    logic [MANT_W-3:0]   m;
    logic [22:0]         frac;
    logic                unf, ovf;
    logic [31:0]         res;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    always_comb begin
        exp_adj  = {2'b00, in_exp} + (in_exp_ctrl == 2'b01 ? one : in_exp_ctrl == 2'b00 ? neg_one : zero_e);
        inexact0 = |in_mant[2:0];
        zero     = in_mant == '0;
    end
`ifdef FPU_RNE_EN
    assign round_up = in_mant[2] & (in_mant[1] | in_mant[0] | in_mant[3]);
`else
    assign round_up = 1'b0;
`endif
    // exp_f is signed: bit EXP_W+1 set means the adjusted exponent went negative
    always_comb begin
        m     = {1'b0, s1_mant} + {{(MANT_W-3){1'b0}}, s1_rup};
        exp_f = s1_exp + {{(EXP_W+1){1'b0}}, m[MANT_W-3]};
        frac  = m[MANT_W-3] ? m[23:1] : m[22:0];
        unf   = exp_f[EXP_W+1] | (exp_f == '0);
        ovf   = ~exp_f[EXP_W+1] & (exp_f[EXP_W] | &exp_f[EXP_W-1:0]);
        res   = s1_zero ? {s1_sign, 31'b0} :
                unf     ? {s1_sign, 31'b0} :
                ovf     ? {s1_sign, 8'hFF, 23'b0} :
                          {s1_sign, exp_f[7:0], frac};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_exp        <= '0;
            s1_mant       <= '0;
            s1_rup        <= 1'b0;
            s1_inx        <= 1'b0;
            s1_zero       <= 1'b1;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= exp_adj;
                s1_mant <= in_mant[MANT_W-1:3];
                s1_rup  <= round_up;
                s1_inx  <= inexact0;
                s1_zero <= zero;
            end
            if (s1_valid) begin
                out_result    <= res;
                out_overflow  <= ~s1_zero & ~unf & ovf;
                out_underflow <= ~s1_zero & unf;
                out_inexact   <= ~s1_zero & (unf | ovf | s1_inx);
            end
        end
    end
endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: random and directed checks of fp_round_pack against an arithmetic reference model
module tb_fp_round_pack;
`ifdef FPU_RNE_EN
    localparam bit rne = 1'b1;
`else
    localparam bit rne = 1'b0;
`endif
    logic        clk = 0, rst = 1, in_valid = 0, in_sign = 0, out_ready = 1;
    logic [7:0]  in_exp = 0;
    logic [26:0] in_mant = 0;
    logic [1:0]  in_exp_ctrl = 2'b10;
    logic        in_ready, out_valid, out_overflow, out_underflow, out_inexact;
    logic [31:0] out_result;
    int          n_chk = 0, n_fail = 0;
    logic [34:0] sb[$];
    logic        obs_valid, obs_in_ready, acc, stall_prev = 0;
    logic [34:0] obs, hold;

    fp_round_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_exp_ctrl(in_exp_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // returns {overflow, underflow, inexact, result}
    function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [26:0] m, input logic [1:0] c);
        int          ex = int'(e) + (c == 2'b01 ? 1 : c == 2'b00 ? -1 : 0);
        int unsigned q = int'(m) / 8;
        int unsigned r = int'(m) % 8;
        logic        inx = r != 0;
        logic [31:0] qv;
        if (rne && (r > 4 || (r == 4 && q % 2 == 1))) q++;
        if (q >= 32'h100_0000) begin
            q = q / 2;
            ex++;
        end
        if (m == 0) return {3'b000, s, 31'b0};
        if (ex <= 0) return {3'b011, s, 31'b0};
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'b0};
        qv = q;
        return {2'b00, inx, s, 8'(ex), qv[22:0]};
    endfunction

    task automatic step(input logic v, input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic [1:0] c, input logic ordy, input logic r);
        @(negedge clk);
        rst = r; in_valid = v; in_sign = s; in_exp = e; in_mant = m; in_exp_ctrl = c; out_ready = ordy;
        #1;
        obs_valid = out_valid;
        obs_in_ready = in_ready;
        obs = {out_overflow, out_underflow, out_inexact, out_result};
        check("in_ready", in_ready, !out_valid || out_ready);
        if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", obs, hold);
        end
        if (!r && out_valid && out_ready) begin
            if (sb.size() == 0) check("spurious", 1, 0);
            else check("result", obs, sb.pop_front());
        end
        acc = !r && v && in_ready;
        if (r) sb.delete();
        else if (acc) sb.push_back(model(s, e, m, c));
        stall_prev = !r && out_valid && !out_ready;
        hold = obs;
    endtask

    task automatic idle(input logic ordy);
        step(0, 0, 8'd0, 27'd0, 2'b10, ordy, 0);
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                            input logic [1:0] c, input logic [34:0] want);
        step(1, s, e, m, c, 1, 0);
        idle(1);
        check({tag, "_early"}, obs_valid, 0);
        idle(1);
        check({tag, "_valid"}, obs_valid, 1);
        check(tag, obs, want);
    endtask

    initial begin
        int sent;
        logic saw_low;
        step(1, 1, 8'd100, 27'h5000000, 2'b10, 1, 1);
        step(1, 1, 8'd100, 27'h5000000, 2'b10, 1, 1);
        idle(1);
        check("rst_valid", obs_valid, 0);
        check("rst_data", obs, 0);
        check("rst_in_ready", obs_in_ready, 1);
        idle(1);
        check("rst_no_accept", obs_valid, 0);

        directed("exact", 0, 8'd127, 27'h6000000, 2'b10, {3'b000, 32'h3FC00000});
        directed("tie_odd", 0, 8'd127, 27'h7FFFFFC, 2'b10, rne ? {3'b001, 32'h40000000} : {3'b001, 32'h3FFFFFFF});
        directed("tie_even", 0, 8'd127, 27'h4000004, 2'b10, {3'b001, 32'h3F800000});
        directed("overflow", 0, 8'd254, 27'h4000000, 2'b01, {3'b101, 32'h7F800000});
        directed("underflow", 1, 8'd1, 27'h4000000, 2'b00, {3'b011, 32'h80000000});
        directed("zero", 0, 8'd90, 27'h0, 2'b10, {3'b000, 32'h0});
        directed("ctrl_rsvd", 0, 8'd127, 27'h6000000, 2'b11, {3'b000, 32'h3FC00000});

        sent = 0;
        saw_low = 0;
        for (int k = 0; k < 16; k++) begin
            step(sent < 3, 0, 8'(120 + sent), 27'h4800000 + 27'(sent), 2'b10, k >= 4, 0);
            if (acc) sent++;
            if (!obs_in_ready) saw_low = 1;
        end
        check("bp_in_ready_drop", saw_low, 1);
        check("bp_sent", sent, 3);
        check("bp_drain", sb.size(), 0);

        step(1, 0, 8'd130, 27'h4400000, 2'b10, 1, 0);
        step(1, 0, 8'd131, 27'h4400000, 2'b10, 1, 0);
        step(1, 0, 8'd132, 27'h4400000, 2'b10, 1, 1);
        idle(1);
        check("midrst_valid", obs_valid, 0);
        for (int k = 0; k < 4; k++) idle(1);
        check("midrst_flushed", sb.size(), 0);

        for (int k = 0; k < 3000; k++) begin
            logic [26:0] m;
            logic [7:0]  e;
            m = ($urandom_range(0, 15) == 0) ? 27'd0 : {1'b1, 26'($urandom)};
            if ($urandom_range(0, 3) == 0) m[2:0] = 3'b100;
            if ($urandom_range(0, 7) == 0) m[26:3] = '1;
            case ($urandom_range(0, 5))
                0: e = 8'd0;
                1: e = 8'd1;
                2: e = 8'd254;
                3: e = 8'd255;
                default: e = 8'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, 1'($urandom), e, m, 2'($urandom), $urandom_range(0, 3) != 0, 0);
        end
        for (int k = 0; k < 30 && sb.size() != 0; k++) idle(1);
        check("rand_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
